// File: rtl/vt_sram_interlock_seq_if.sv
// Handshake bundle between the host/SRAM requesters and the translator interlock sequencer.
// Signal prefixes are from the sequencer's point of view: i_ into it, o_ out of it.
interface vt_sram_interlock_seq_if;
    logic       i_vt_req;
    logic       i_sram_rd_req;
    logic       o_vt_en_in;
    logic       o_vt_ready;
    logic       o_sram_rd_gnt;
    logic [2:0] o_state;
    logic       o_timeout_err;

    modport master (
        output i_vt_req, i_sram_rd_req,
        input  o_vt_en_in, o_vt_ready, o_sram_rd_gnt, o_state, o_timeout_err
    );

    modport slave (
        input  i_vt_req, i_sram_rd_req,
        output o_vt_en_in, o_vt_ready, o_sram_rd_gnt, o_state, o_timeout_err
    );
endinterface

// File: rtl/vt_sram_interlock_seq.sv
// Interlock sequencer: keeps voltage translators off with settle/guard intervals around SRAM reads.
// Optional grant timeout is compiled in with the VT_INTERLOCK_TIMEOUT_EN macro.
module vt_sram_interlock_seq #(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned GUARD_CYC   = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    vt_sram_interlock_seq_if.slave   io_bus
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StVtSettle = 3'd1,
        StVtOn     = 3'd2,
        StVtGuard  = 3'd3,
        StSramRd   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GuardLoad  = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W:0]   GuardFull  = (CNT_W + 1)'(GUARD_CYC);

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_vt_en_in, r_vt_ready, r_sram_rd_gnt;
    logic             w_rd_req;
    logic             w_timeout;

`ifdef VT_INTERLOCK_TIMEOUT_EN
    localparam int unsigned     GntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GntW-1:0] GntLast = GntW'(TIMEOUT_CYC - 1);

    logic [GntW-1:0] r_gnt_cnt, w_gnt_cnt_d;
    logic            r_timeout_err, w_timeout_err_d;
    logic            r_wait_low, w_wait_low_d;

    // After a timeout the requester must drop its request before it can be granted again.
    assign w_rd_req  = io_bus.i_sram_rd_req & ~r_wait_low;
    assign w_timeout = (r_state == StSramRd) && (r_gnt_cnt == GntLast);

    always_comb begin
        w_gnt_cnt_d     = '0;
        w_timeout_err_d = r_timeout_err;
        w_wait_low_d    = r_wait_low;
        if (r_state == StSramRd && !w_timeout) begin
            w_gnt_cnt_d = r_gnt_cnt + 1'b1;
        end
        if (w_timeout) begin
            w_timeout_err_d = 1'b1;
            w_wait_low_d    = 1'b1;
        end else if (!io_bus.i_sram_rd_req) begin
            w_wait_low_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt_cnt     <= '0;
            r_timeout_err <= 1'b0;
            r_wait_low    <= 1'b0;
        end else begin
            r_gnt_cnt     <= w_gnt_cnt_d;
            r_timeout_err <= w_timeout_err_d;
            r_wait_low    <= w_wait_low_d;
        end
    end

    assign io_bus.o_timeout_err = r_timeout_err;
`else
    assign w_rd_req             = io_bus.i_sram_rd_req;
    assign w_timeout            = 1'b0;
    assign io_bus.o_timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_rd_req) begin
                    w_state_d = StSramRd;
                end else if (io_bus.i_vt_req) begin
                    w_state_d = StVtSettle;
                    w_cnt_d   = SettleLoad;
                end
            end
            StVtSettle: begin
                if (w_rd_req || !io_bus.i_vt_req) begin
                    w_state_d = StVtGuard;
                    w_cnt_d   = GuardLoad;
                end else if (r_cnt == '0) begin
                    w_state_d = StVtOn;
                end else begin
                    w_cnt_d   = r_cnt - 1'b1;
                end
            end
            StVtOn: begin
                if (w_rd_req || !io_bus.i_vt_req) begin
                    w_state_d = StVtGuard;
                    w_cnt_d   = GuardLoad;
                end
            end
            StVtGuard: begin
                // Inputs are only sampled once the full guard has elapsed.
                if (r_cnt == '0) begin
                    w_state_d = w_rd_req ? StSramRd : StIdle;
                end else begin
                    w_cnt_d   = r_cnt - 1'b1;
                end
            end
            StSramRd: begin
                if (w_timeout || !w_rd_req) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs decode the next state so they switch together with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_vt_en_in    <= 1'b0;
            r_vt_ready    <= 1'b0;
            r_sram_rd_gnt <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_vt_en_in    <= (w_state_d == StVtSettle) || (w_state_d == StVtOn);
            r_vt_ready    <= (w_state_d == StVtOn);
            r_sram_rd_gnt <= (w_state_d == StSramRd);
        end
    end

    assign io_bus.o_vt_en_in    = r_vt_en_in;
    assign io_bus.o_vt_ready    = r_vt_ready;
    assign io_bus.o_sram_rd_gnt = r_sram_rd_gnt;
    assign io_bus.o_state       = r_state;

    // Consecutive cycles with the enable low; reset counts as a full guard since it forces it low.
    logic [CNT_W:0] r_off_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_off_cnt <= GuardFull;
        end else if (r_vt_en_in) begin
            r_off_cnt <= '0;
        end else if (r_off_cnt < GuardFull) begin
            r_off_cnt <= r_off_cnt + 1'b1;
        end
    end

    a_params: assert property (@(posedge i_clk)
        (SETTLE_CYC >= 1) && (GUARD_CYC >= 2) && (TIMEOUT_CYC >= 1));

    a_mutex: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(r_vt_en_in && r_sram_rd_gnt));

    a_guard: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $rose(r_sram_rd_gnt) |-> (r_off_cnt >= GuardFull));

endmodule

// File: tb/tb_vt_sram_interlock_seq.sv
// Bench for vt_sram_interlock_seq: directed vector table, async reset sequences and a
// randomized run checked against an interval-based reference model.
module tb_vt_sram_interlock_seq;

    localparam int unsigned SETTLE = 8;
    localparam int unsigned GUARD  = 4;
    localparam int unsigned TOUT   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vt_sram_interlock_seq_if bus ();

    vt_sram_interlock_seq #(
        .SETTLE_CYC (SETTLE),
        .GUARD_CYC  (GUARD),
        .CNT_W      (8),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit       vt;
        bit       rd;
        bit       en;
        bit       rdy;
        bit       gnt;
        bit [2:0] st;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit vt, bit rd, bit en, bit rdy, bit gnt, bit [2:0] st);
        vec_t v;
        v.vt = vt; v.rd = rd; v.en = en; v.rdy = rdy; v.gnt = gnt; v.st = st;
        tv.push_back(v);
    endfunction

    // {en, ready, gnt, state[2:0], timeout_err}
    function automatic logic [6:0] obs();
        return {bus.o_vt_en_in, bus.o_vt_ready, bus.o_sram_rd_gnt, bus.o_state,
                bus.o_timeout_err};
    endfunction

    task automatic check(string name, logic [6:0] act, logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: en/rdy/gnt/state/err got %b required %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: "enabled" is one mode whose age decides readiness; guard and grant
    // are tracked as elapsed-cycle counts.
    int m_mode;  // 0 off, 1 enabled, 2 guard, 3 granted
    int m_age, m_glen, m_gcnt;
    bit m_err, m_block;

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_glen = 0; m_gcnt = 0; m_err = 0; m_block = 0;
    endtask

    task automatic model_step(bit vt, bit rd);
        bit rde, to;
        rde = rd && !m_block;
        to  = 0;
        case (m_mode)
            0: begin
                if (rde) begin m_mode = 3; m_gcnt = 0; end
                else if (vt) begin m_mode = 1; m_age = 1; end
            end
            1: begin
                if (rde || !vt) begin m_mode = 2; m_glen = 1; end
                else m_age++;
            end
            2: begin
                if (m_glen == GUARD) begin m_mode = rde ? 3 : 0; m_gcnt = 0; end
                else m_glen++;
            end
            default: begin
`ifdef VT_INTERLOCK_TIMEOUT_EN
                m_gcnt++;
                if (m_gcnt == TOUT) begin to = 1; m_mode = 0; end
`endif
                if (!to && !rde) m_mode = 0;
            end
        endcase
`ifdef VT_INTERLOCK_TIMEOUT_EN
        if (to) begin m_err = 1; m_block = 1; end
        else if (!rd) m_block = 0;
`endif
    endtask

    function automatic logic [6:0] model_exp();
        logic en, rdy, gnt;
        logic [2:0] st;
        en  = (m_mode == 1);
        rdy = en && (m_age > SETTLE);
        gnt = (m_mode == 3);
        st  = (m_mode == 0) ? 3'd0 : (m_mode == 1) ? (rdy ? 3'd2 : 3'd1) :
              (m_mode == 2) ? 3'd3 : 3'd4;
        return {en, rdy, gnt, st, m_err};
    endfunction

    task automatic tick(bit vt, bit rd);
        bus.i_vt_req      = vt;
        bus.i_sram_rd_req = rd;
        @(posedge clk);
        model_step(vt, rd);
        #1;
    endtask

    // Pulls reset low between edges and expects outputs to clear before any clock.
    task automatic async_reset(string name);
        #2;
        rst_n = 1'b0;
        #1;
        check(name, obs(), 7'd0);
        model_reset();
        bus.i_vt_req      = 1'b0;
        bus.i_sram_rd_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(0, 0);
        check({name, "_rel"}, obs(), 7'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit vt, rd;
        int gcount;

        bus.i_vt_req      = 1'b0;
        bus.i_sram_rd_req = 1'b0;
        model_reset();

        // Enable, settle, then a read interrupts the ready translators.
        for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 0, 3'd1);
        add(1, 0, 1, 1, 0, 3'd2);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 3'd3);
        add(1, 1, 0, 0, 1, 3'd4);
        add(1, 1, 0, 0, 1, 3'd4);
        add(1, 0, 0, 0, 0, 3'd0);
        add(1, 0, 1, 0, 0, 3'd1);
        // Host drops its request mid-settle.
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 3'd3);
        add(0, 0, 0, 0, 0, 3'd0);
        // Both requests together in idle: read wins.
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 1, 3'd4);
        add(1, 0, 0, 0, 0, 3'd0);
        // Read arrives at settle count 3.
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 0, 3'd1);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 3'd3);
        add(1, 1, 0, 0, 1, 3'd4);
        add(0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", obs(), 7'd0);
        #1;
        rst_n = 1'b1;

        foreach (tv[i]) begin
            tick(tv[i].vt, tv[i].rd);
            check($sformatf("vec%0d", i), obs(),
                  {tv[i].en, tv[i].rdy, tv[i].gnt, tv[i].st, 1'b0});
        end
        check("model_sync", obs(), model_exp());

        // Reset while guarding.
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        check("pre_guard", obs(), 7'b0000110);
        async_reset("rst_guard");

        // Reset while granted.
        tick(0, 1);
        tick(0, 1);
        check("pre_grant", obs(), 7'b0011000);
        async_reset("rst_grant");

`ifdef VT_INTERLOCK_TIMEOUT_EN
        gcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1);
            if (bus.o_sram_rd_gnt) gcount++;
        end
        n_cmp++;
        if (gcount != TOUT) begin
            n_fail++;
            $display("FAIL timeout_len: grant cycles got %0d required %0d", gcount, TOUT);
        end
        check("timeout_hold", obs(), 7'b0000001);
        tick(0, 0);
        tick(0, 1);
        check("timeout_regrant", obs(), 7'b0011001);
        tick(0, 0);
`else
        gcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1);
            if (bus.o_sram_rd_gnt) gcount++;
        end
        n_cmp++;
        if (gcount != 40) begin
            n_fail++;
            $display("FAIL no_timeout: grant cycles got %0d required 40", gcount);
        end
        tick(0, 0);
        check("grant_release", obs(), 7'd0);
`endif

        vt = 0;
        rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) vt = ~vt;
            if ($urandom_range(11) == 0) rd = ~rd;
            tick(vt, rd);
            check("rand", obs(), model_exp());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vt_sram_interlock_seq.md
Name: vt_sram_interlock_seq

Overview:
- Sequencer directly upstream of the voltage translator controller. It generates that controller's enable input (VT_EN_IN).
- Arbitrates between host requests to enable the translators and SRAM read requests.
- Guarantees translators are never enabled while an SRAM read is granted, with settle and guard intervals around every transition.

Parameters:
- SETTLE_CYC, 8: cycles VT_EN_IN is high before VT_READY asserts; legal range 1..2^CNT_W-1.
- GUARD_CYC, 4: cycles VT_EN_IN is low before SRAM_RD_GNT may assert; minimum 2, to cover the one-cycle register in the downstream controller.
- CNT_W, 8: width of the shared interval counter.
- TIMEOUT_CYC, 1024: maximum grant length; used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous reset, active-low; all state clears immediately on assertion.
- VT_REQ  in  1  level; host wants translators enabled.
- SRAM_RD_REQ  in  1  level; requester holds it high for the whole read.
- VT_EN_IN  out  1  enable to the translator controller's EN_IN.
- VT_READY  out  1  translators enabled and settled.
- SRAM_RD_GNT  out  1  SRAM read may proceed; translators guaranteed off.
- STATE  out  3  current state encoding, for debug.
- TIMEOUT_ERR  out  1  sticky grant-timeout flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset values: state IDLE; counter 0; VT_EN_IN, VT_READY, SRAM_RD_GNT and TIMEOUT_ERR all 0; STATE 3'd0.
- States: IDLE=0, VT_SETTLE=1, VT_ON=2, VT_GUARD=3, SRAM_RD=4. Encodings 5..7 are illegal and return to IDLE next cycle.
- Moore outputs are registered and decoded from the next state, so each output changes in the same cycle as the state:
  - VT_EN_IN = (VT_SETTLE or VT_ON)
  - VT_READY = VT_ON
  - SRAM_RD_GNT = SRAM_RD
- IDLE:
  - SRAM_RD_REQ -> SRAM_RD. SRAM has priority when both requests are high.
  - else VT_REQ -> VT_SETTLE; load counter = SETTLE_CYC-1.
  - Granting directly from IDLE is legal: IDLE is only entered from reset, VT_GUARD or SRAM_RD, so translators have already been off at least GUARD_CYC cycles.
- VT_SETTLE:
  - SRAM_RD_REQ or !VT_REQ -> VT_GUARD; load counter = GUARD_CYC-1.
  - else if counter==0 -> VT_ON.
  - else decrement counter.
  - Net effect: VT_SETTLE lasts exactly SETTLE_CYC cycles when uninterrupted.
- VT_ON:
  - SRAM_RD_REQ or !VT_REQ -> VT_GUARD; load counter = GUARD_CYC-1.
- VT_GUARD:
  - VT_EN_IN is 0. Inputs are ignored until counter==0; the state lasts exactly GUARD_CYC cycles.
  - At counter==0: SRAM_RD_REQ -> SRAM_RD, else IDLE.
- SRAM_RD:
  - Hold grant while SRAM_RD_REQ is high.
  - SRAM_RD_REQ low -> IDLE; grant drops in the cycle after the request falls.
  - VT_REQ is ignored in this state. If VT_REQ is still high on return to IDLE, VT_SETTLE follows next cycle.
- Invariants (checked by assertion):
  - SRAM_RD_GNT and VT_EN_IN are never both 1.
  - Every rising edge of SRAM_RD_GNT is preceded by at least GUARD_CYC cycles of VT_EN_IN=0.
- Simultaneous events: SRAM_RD_REQ dominates VT_REQ in every state. A VT_REQ drop and a read request arriving in the same cycle take the same single path to VT_GUARD.
- Reset mid-operation: outputs go low asynchronously, including mid-guard or mid-grant. After release, start is IDLE with no guard, since VT_EN_IN was forced low by reset.

Optional Feature:
- Macro: VT_INTERLOCK_TIMEOUT_EN.
- Defined:
  - A CNT_W-independent grant counter (width $clog2(TIMEOUT_CYC+1)) counts cycles in SRAM_RD.
  - On reaching TIMEOUT_CYC: force the next state to IDLE and set TIMEOUT_ERR sticky (cleared only by RST).
  - While TIMEOUT_ERR=1, remain in IDLE until SRAM_RD_REQ has been low for at least one cycle; VT_REQ is still served.
- Undefined: no grant counter; a grant lasts indefinitely; TIMEOUT_ERR tied to 0.

Test Plan:
- Reset then VT_REQ=1 held, defaults:
  - VT_EN_IN rises 1 cycle after the request.
  - VT_READY rises 8 cycles after VT_EN_IN.
  - SRAM_RD_GNT stays 0.
- In VT_ON, pulse SRAM_RD_REQ high and hold:
  - VT_EN_IN and VT_READY fall next cycle.
  - SRAM_RD_GNT rises exactly 4 cycles after VT_EN_IN falls.
  - Drop REQ: GNT falls next cycle; with VT_REQ still 1, VT_EN_IN rises 2 cycles later.
- VT_REQ and SRAM_RD_REQ rise together in IDLE:
  - GNT=1 next cycle; VT_EN_IN stays 0 throughout the read.
- SRAM_RD_REQ arrives at settle count 3:
  - VT_SETTLE aborts; VT_READY never asserts.
  - Full 4-cycle guard, then grant.
- Assert RST low during VT_GUARD and during SRAM_RD:
  - All outputs 0 without waiting for a clock edge; STATE=0 after release.
- With VT_INTERLOCK_TIMEOUT_EN and TIMEOUT_CYC=16, hold SRAM_RD_REQ 40 cycles:
  - GNT falls after 16 cycles; TIMEOUT_ERR=1 and stays 1.
  - No re-grant until REQ goes low then high.
